fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Samples the current PC, issues a valid/ready request to instruction memory and waits for the response.
- Presents the fetched word plus its PC to decode over a valid/ready handshake.
- Emits a one-cycle pc_advance pulse that gates the PC register update, so the PC only moves once the instruction is consumed.

---
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: PC/redirect inputs, imem request/response and decode handshake of the fetch stage.
// fetch_fault exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc;
   logic            flush;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            pc_advance;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic            fetch_fault;
`endif
   modport master (
      input  pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, pc_advance
`ifdef FETCH_MISALIGN_TRAP_EN
      , output fetch_fault
`endif
   );
   modport slave (
      output pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, pc_advance
`ifdef FETCH_MISALIGN_TRAP_EN
      , input fetch_fault
`endif
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetches one instruction per PC and holds it for decode; pc_advance releases the PC register.
// FETCH_MISALIGN_TRAP_EN: misaligned PCs skip memory and present a NOP with fetch_fault.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, REQ, WAIT, HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
      , FAULT
`endif
   } state_t;
   state_t          state_q, state_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] addr_q, addr_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         drop_q    <= 1'b0;
         addr_q    <= '0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         drop_q    <= drop_d;
         addr_q    <= addr_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end
   always_comb begin
      state_d            = state_q;
      drop_d             = drop_q;
      addr_d             = addr_q;
      inst_d             = inst_q;
      inst_pc_d          = inst_pc_q;
      bus.imem_req_valid = 1'b0;
      bus.inst_valid     = 1'b0;
      bus.pc_advance     = 1'b0;
      case (state_q)
         IDLE: begin
            addr_d = bus.pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (!bus.flush) state_d = (bus.pc[1:0] != 2'b00) ? FAULT : REQ;
`else
            if (!bus.flush) state_d = REQ;
`endif
         end
         REQ: begin
            // a flushed request still completes; its response is dropped later
            bus.imem_req_valid = 1'b1;
            drop_d             = drop_q | bus.flush;
            if (bus.imem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            drop_d = drop_q | bus.flush;
            if (bus.imem_rsp_valid) begin
               drop_d  = 1'b0;
               state_d = (drop_q || bus.flush) ? IDLE : HOLD;
               if (!(drop_q || bus.flush)) begin
                  inst_d    = bus.imem_rsp_data;
                  inst_pc_d = addr_q;
               end
            end
         end
         HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
         , FAULT
`endif
         : begin
            bus.inst_valid = 1'b1;
            bus.pc_advance = bus.inst_ready & ~bus.flush;
            if (bus.flush || bus.inst_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault;
   assign fault             = (state_q == FAULT);
   assign bus.fetch_fault   = fault;
   assign bus.inst          = fault ? NOP_INST : inst_q;
   assign bus.inst_pc       = fault ? addr_q : inst_pc_q;
   assign bus.imem_req_addr = addr_q;
`else
   logic unused_nop;
   assign unused_nop        = ^NOP_INST;
   assign bus.inst          = inst_q;
   assign bus.inst_pc       = inst_pc_q;
   assign bus.imem_req_addr = {addr_q[XLEN-1:2], 2'b00};
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a random run against a PC-register/memory/decode model.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   fetch_unit_if #(.XLEN(32)) bus ();
   fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int n_chk = 0;
   int n_fail = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      bus.flush          = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.inst_ready     = 1'b0;
   endtask
   task automatic check_zero(input string t);
      @(negedge clk);
      chk({t, "_req_valid"}, 32'(bus.imem_req_valid), 0);
      chk({t, "_req_addr"}, bus.imem_req_addr, 0);
      chk({t, "_inst_valid"}, 32'(bus.inst_valid), 0);
      chk({t, "_inst"}, bus.inst, 0);
      chk({t, "_inst_pc"}, bus.inst_pc, 0);
      chk({t, "_pc_advance"}, 32'(bus.pc_advance), 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk({t, "_fetch_fault"}, 32'(bus.fetch_fault), 0);
`endif
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      bus.pc = '0;
      tick();
      tick();
      check_zero("rst");
      tick();
      rst_n = 1'b1;
   endtask
   // entered at the start of an IDLE cycle, returns at the start of HOLD
   task automatic fetch_to_hold(input logic [31:0] a, ea, d, input int stall);
      bus.pc         = a;
      bus.inst_ready = 1'b0;
      @(negedge clk);
      chk("idle_req", 32'(bus.imem_req_valid), 0);
      chk("idle_iv", 32'(bus.inst_valid), 0);
      chk("idle_adv", 32'(bus.pc_advance), 0);
      tick();
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(bus.imem_req_valid), 1);
         chk("stall_addr", bus.imem_req_addr, ea);
         tick();
      end
      bus.imem_req_ready = 1'b1;
      @(negedge clk);
      chk("req_valid", 32'(bus.imem_req_valid), 1);
      chk("req_addr", bus.imem_req_addr, ea);
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = d;
      @(negedge clk);
      chk("wait_req", 32'(bus.imem_req_valid), 0);
      chk("wait_iv", 32'(bus.inst_valid), 0);
      tick();
      bus.imem_rsp_valid = 1'b0;
   endtask
   task automatic consume(input logic [31:0] a, d);
      bus.inst_ready = 1'b1;
      @(negedge clk);
      chk("hold_iv", 32'(bus.inst_valid), 1);
      chk("hold_inst", bus.inst, d);
      chk("hold_pc", bus.inst_pc, a);
      chk("hold_adv", 32'(bus.pc_advance), 1);
      tick();
      bus.inst_ready = 1'b0;
      bus.pc = bus.pc + 32'd4;
   endtask
   logic [31:0] pc_reg, pc_next, flush_tgt, raddr, prev_addr, prev_inst, prev_inst_pc, req_addr_s;
   logic        pending, rsp_real, req_fire, fire, adv_exp, garbage;
   logic        prev_fire, prev_flush, prev_hold_stall, prev_req_stall;
   int          cnt, delivered;
   initial begin
      do_reset();
      fetch_to_hold(32'h0, 32'h0, 32'h00500093, 0);
      consume(32'h0, 32'h00500093);
      fetch_to_hold(32'h4, 32'h4, 32'h00A00113, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_iv", 32'(bus.inst_valid), 1);
         chk("bp_inst", bus.inst, 32'h00A00113);
         chk("bp_pc", bus.inst_pc, 32'h4);
         chk("bp_adv", 32'(bus.pc_advance), 0);
         tick();
      end
      consume(32'h4, 32'h00A00113);
      fetch_to_hold(32'h10, 32'h10, 32'h00C00193, 3);
      consume(32'h10, 32'h00C00193);
      bus.pc = 32'h20;
      tick();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.flush = 1'b1;
      @(negedge clk);
      chk("fw_iv", 32'(bus.inst_valid), 0);
      tick();
      bus.flush          = 1'b0;
      bus.pc             = 32'h40;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEADBEEF;
      @(negedge clk);
      chk("fw_rsp_iv", 32'(bus.inst_valid), 0);
      tick();
      bus.imem_rsp_valid = 1'b0;
      fetch_to_hold(32'h40, 32'h40, 32'h02000213, 0);
      bus.flush      = 1'b1;
      bus.inst_ready = 1'b1;
      @(negedge clk);
      chk("fh_iv", 32'(bus.inst_valid), 1);
      chk("fh_adv", 32'(bus.pc_advance), 0);
      tick();
      bus.flush      = 1'b0;
      bus.inst_ready = 1'b0;
      fetch_to_hold(32'h80, 32'h80, 32'h00100293, 0);
      consume(32'h80, 32'h00100293);
      bus.pc = 32'h84;
      tick();
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n              = 1'b1;
      bus.pc             = 32'h90;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBAD0BAD0;
      check_zero("rw");
      tick();
      @(negedge clk);
      chk("rw_req_valid", 32'(bus.imem_req_valid), 1);
      chk("rw_req_addr", bus.imem_req_addr, 32'h90);
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_data  = 32'h00200313;
      @(negedge clk);
      chk("rw_wait_iv", 32'(bus.inst_valid), 0);
      tick();
      bus.imem_rsp_valid = 1'b0;
      consume(32'h90, 32'h00200313);
`ifdef FETCH_MISALIGN_TRAP_EN
      bus.pc = 32'h102;
      tick();
      @(negedge clk);
      chk("mf_req", 32'(bus.imem_req_valid), 0);
      chk("mf_iv", 32'(bus.inst_valid), 1);
      chk("mf_inst", bus.inst, 32'h00000013);
      chk("mf_pc", bus.inst_pc, 32'h102);
      chk("mf_fault", 32'(bus.fetch_fault), 1);
      chk("mf_adv0", 32'(bus.pc_advance), 0);
      bus.inst_ready = 1'b1;
      #1;
      chk("mf_adv", 32'(bus.pc_advance), 1);
      tick();
      bus.inst_ready = 1'b0;
      bus.pc = 32'h106;
      @(negedge clk);
      chk("mf_fault_clr", 32'(bus.fetch_fault), 0);
`else
      fetch_to_hold(32'h102, 32'h100, 32'h00300393, 0);
      consume(32'h102, 32'h00300393);
`endif
      // random run: tb acts as PC register, memory with 1-3 cycle latency and decode
      do_reset();
      pc_reg = 32'h1000;
      bus.pc = pc_reg;
      {pending, rsp_real, prev_fire, prev_flush, prev_hold_stall, prev_req_stall} = '0;
      {prev_addr, prev_inst, prev_inst_pc, raddr, flush_tgt} = '0;
      cnt = 0;
      delivered = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         fire    = bus.inst_valid && bus.inst_ready;
         adv_exp = fire && !bus.flush;
         chk("r_adv", 32'(bus.pc_advance), 32'(adv_exp));
         if (adv_exp) begin
            chk("r_inst_pc", bus.inst_pc, pc_reg);
            chk("r_inst", bus.inst, mem_word(pc_reg));
            delivered++;
         end
         if (prev_fire || prev_flush) chk("r_iv_after", 32'(bus.inst_valid), 0);
         if (prev_hold_stall) begin
            chk("r_bp_iv", 32'(bus.inst_valid), 1);
            chk("r_bp_inst", bus.inst, prev_inst);
            chk("r_bp_pc", bus.inst_pc, prev_inst_pc);
         end
         if (prev_req_stall) begin
            chk("r_req_hold", 32'(bus.imem_req_valid), 1);
            chk("r_req_addr", bus.imem_req_addr, prev_addr);
         end
         if (bus.imem_req_valid) chk("r_one_out", 32'(pending), 0);
         req_fire        = bus.imem_req_valid && bus.imem_req_ready;
         req_addr_s      = bus.imem_req_addr;
         prev_fire       = fire;
         prev_flush      = bus.flush;
         prev_hold_stall = bus.inst_valid && !bus.inst_ready && !bus.flush;
         prev_req_stall  = bus.imem_req_valid && !bus.imem_req_ready;
         prev_addr       = bus.imem_req_addr;
         prev_inst       = bus.inst;
         prev_inst_pc    = bus.inst_pc;
         pc_next = bus.flush ? flush_tgt : adv_exp ? pc_reg + 32'd4 : pc_reg;
         tick();
         pc_reg = pc_next;
         bus.pc = pc_reg;
         if (rsp_real) pending = 1'b0;
         if (req_fire) begin
            pending = 1'b1;
            cnt     = int'($urandom_range(0, 2));
            raddr   = req_addr_s;
         end else if (pending && cnt > 0) cnt--;
         rsp_real           = pending && cnt == 0;
         garbage            = !pending && $urandom_range(0, 3) == 0;
         bus.imem_rsp_valid = rsp_real || garbage;
         bus.imem_rsp_data  = rsp_real ? mem_word(raddr) : 32'hBAD0BAD0;
         bus.imem_req_ready = 1'($urandom_range(0, 1));
         bus.inst_ready     = 1'($urandom_range(0, 1));
         bus.flush          = $urandom_range(0, 19) == 0;
         flush_tgt          = $urandom & 32'h0003FFFC;
      end
      chk("r_progress", 32'(delivered > 50), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
